// File: rtl/code_patch_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : code_patch_wb_pipe
// Description : Pipelined Wishbone pass-through that substitutes read data for
//               up to NUM_REGS programmable addresses ("code patches").
//               Reads that hit an enabled entry are answered locally and never
//               reach the bus side. All other requests are forwarded
//               combinationally. An in-order tracking FIFO keeps local and bus
//               responses in request order.
// Macro       : CODE_PATCH_HIT_CNT_EN - when defined, adds 16-bit saturating
//               per-entry hit counters. When undefined, hit_cnt_o is tied to
//               zero and no counter flops exist.
// Ports       : clk_i, rst_i           - clock, async active-high reset
//               wb_si_*                - CPU-side pipelined Wishbone slave
//               wb_mi_*                - bus-side pipelined Wishbone master
//               cfg_patch_en_i         - global patch enable
//               ctl_pat_addr/data/en_i - patch table
//               hit_cnt_o              - per-entry hit counters
// Revision    : 1.0 - initial release
// ============================================================================
module code_patch_wb_pipe #(
  parameter int  ADDR_WIDTH = 32,
  parameter int  DATA_WIDTH = 32,
  parameter int  NUM_REGS   = 4,
  parameter int  MAX_OUTST  = 4,
  localparam int SEL_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // CPU side
  input  logic                  wb_si_cyc_i,
  input  logic                  wb_si_stb_i,
  input  logic                  wb_si_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_si_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_si_dat_i,
  input  logic [SEL_WIDTH-1:0]  wb_si_sel_i,
  output logic [DATA_WIDTH-1:0] wb_si_dat_o,
  output logic                  wb_si_ack_o,
  output logic                  wb_si_err_o,
  output logic                  wb_si_stall_o,
  // Bus side
  output logic                  wb_mi_cyc_o,
  output logic                  wb_mi_stb_o,
  output logic                  wb_mi_we_o,
  output logic [ADDR_WIDTH-1:0] wb_mi_adr_o,
  output logic [DATA_WIDTH-1:0] wb_mi_dat_o,
  output logic [SEL_WIDTH-1:0]  wb_mi_sel_o,
  input  logic [DATA_WIDTH-1:0] wb_mi_dat_i,
  input  logic                  wb_mi_ack_i,
  input  logic                  wb_mi_err_i,
  input  logic                  wb_mi_stall_i,
  // Patch control
  input  logic                  cfg_patch_en_i,
  input  logic [ADDR_WIDTH-1:0] ctl_pat_addr_i [NUM_REGS],
  input  logic [DATA_WIDTH-1:0] ctl_pat_data_i [NUM_REGS],
  input  logic [NUM_REGS-1:0]   ctl_pat_en_i,
  output logic [15:0]           hit_cnt_o [NUM_REGS]
);

  localparam int               PTR_W  = $clog2(MAX_OUTST);
  localparam int               CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(MAX_OUTST);

  // --------------------------------------------------------------------------
  // Patch table lookup
  // --------------------------------------------------------------------------
  logic [NUM_REGS-1:0]   pat_match;
  logic                  hit;
  logic [DATA_WIDTH-1:0] hit_data;

  // Scanning from the top down lets the lowest matching entry win.
  always_comb begin
    pat_match = '0;
    hit_data  = '0;
    for (int k = NUM_REGS - 1; k >= 0; k--) begin
      pat_match[k] = wb_si_cyc_i & wb_si_stb_i & ~wb_si_we_i & cfg_patch_en_i &
                     ctl_pat_en_i[k] & (wb_si_adr_i == ctl_pat_addr_i[k]);
      if (pat_match[k]) begin
        hit_data = ctl_pat_data_i[k];
      end
    end
  end

  assign hit = |pat_match;

  // --------------------------------------------------------------------------
  // Response-ordering FIFO. Each entry records whether it is answered locally
  // and, if so, the data to return. The entry index is not kept because the
  // counters are updated at accept time.
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [MAX_OUTST-1:0]  patched_q, patched_d;
  logic [DATA_WIDTH-1:0] data_q [MAX_OUTST];
  logic [DATA_WIDTH-1:0] data_d [MAX_OUTST];
  logic                  pat_ack_q, pat_ack_d;

  logic fifo_empty;
  logic fifo_full;
  logic head_fwd;
  logic accept;
  logic fwd_resp;
  logic pat_pop;
  logic pop;

  assign fifo_empty    = (count_q == '0);
  assign fifo_full     = (count_q == C_FULL);
  assign head_fwd      = ~fifo_empty & ~patched_q[rd_ptr_q];

  assign wb_si_stall_o = fifo_full | (~hit & wb_mi_stall_i);
  assign accept        = wb_si_cyc_i & wb_si_stb_i & ~wb_si_stall_o;

  // Bus responses are consumed only when the head is a forwarded request;
  // anything else (empty FIFO, patched head) is stray and dropped.
  assign fwd_resp      = wb_si_cyc_i & head_fwd & (wb_mi_ack_i | wb_mi_err_i);
  // pat_ack_q is only ever set while a patched entry is at the head.
  assign pat_pop       = wb_si_cyc_i & pat_ack_q;
  assign pop           = fwd_resp | pat_pop;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    patched_d = patched_q;
    data_d    = data_q;
    pat_ack_d = 1'b0;

    if (!wb_si_cyc_i) begin
      // End of bus cycle: abandon all outstanding requests.
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        patched_d[wr_ptr_q] = hit;
        data_d[wr_ptr_q]    = hit_data;
        wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(accept) - CNT_W'(pop);
      // Look at the entry that will sit at the head next cycle (including one
      // being pushed right now into an otherwise drained FIFO). If it is a
      // patched entry, its ack is issued in that next cycle.
      if (count_d != '0) begin
        pat_ack_d = patched_d[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      patched_q <= '0;
      pat_ack_q <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      patched_q <= patched_d;
      pat_ack_q <= pat_ack_d;
      data_q    <= data_d;
    end
  end

  // --------------------------------------------------------------------------
  // CPU-side response
  // --------------------------------------------------------------------------
  assign wb_si_ack_o = pat_pop | (wb_si_cyc_i & head_fwd & wb_mi_ack_i);
  assign wb_si_err_o = wb_si_cyc_i & head_fwd & wb_mi_err_i;

  always_comb begin
    wb_si_dat_o = '0;
    if (pat_pop) begin
      wb_si_dat_o = data_q[rd_ptr_q];
    end else if (wb_si_cyc_i && head_fwd && wb_mi_ack_i) begin
      wb_si_dat_o = wb_mi_dat_i;
    end
  end

  // --------------------------------------------------------------------------
  // Bus-side request: everything except a patch hit passes straight through.
  // --------------------------------------------------------------------------
  assign wb_mi_cyc_o = wb_si_cyc_i;
  assign wb_mi_stb_o = wb_si_stb_i & ~hit & ~fifo_full;
  assign wb_mi_we_o  = wb_si_we_i;
  assign wb_mi_adr_o = wb_si_adr_i;
  assign wb_mi_dat_o = wb_si_dat_i;
  assign wb_mi_sel_o = wb_si_sel_i;

  // --------------------------------------------------------------------------
  // Hit counters
  // --------------------------------------------------------------------------
`ifdef CODE_PATCH_HIT_CNT_EN
  logic [15:0] hit_cnt_q [NUM_REGS];
  logic [15:0] hit_cnt_d [NUM_REGS];

  always_comb begin : p_hit_cnt_next
    logic seen_lower;
    seen_lower = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      hit_cnt_d[k] = hit_cnt_q[k];
      // Only the winning (lowest) entry counts; the counter saturates.
      if (accept && pat_match[k] && !seen_lower && (hit_cnt_q[k] != 16'hFFFF)) begin
        hit_cnt_d[k] = hit_cnt_q[k] + 16'd1;
      end
      seen_lower = seen_lower | pat_match[k];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        hit_cnt_q[k] <= '0;
      end
    end else begin
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign hit_cnt_o = hit_cnt_q;
`else
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      hit_cnt_o[k] = '0;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_code_patch_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_code_patch_wb_pipe
// Description : Self-checking bench for code_patch_wb_pipe. A table of
//               single-request vectors covers lookup, forwarding and stall
//               decisions; hand-written sequences cover ordering, FIFO-full
//               stall, cycle abort, stray responses and error pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_code_patch_wb_pipe;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int MO = 4;
  localparam int SW = DW / 8;

`ifdef CODE_PATCH_HIT_CNT_EN
  localparam logic [15:0] C_CNT_ONE = 16'd1;
  localparam logic [15:0] C_CNT_TWO = 16'd2;
`else
  localparam logic [15:0] C_CNT_ONE = 16'd0;
  localparam logic [15:0] C_CNT_TWO = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          si_cyc, si_stb, si_we;
  logic [AW-1:0] si_adr;
  logic [DW-1:0] si_dat_i;
  logic [SW-1:0] si_sel;
  logic [DW-1:0] si_dat_o;
  logic          si_ack, si_err, si_stall;
  logic          mi_cyc, mi_stb, mi_we;
  logic [AW-1:0] mi_adr;
  logic [DW-1:0] mi_dat_o;
  logic [SW-1:0] mi_sel;
  logic [DW-1:0] mi_dat_i;
  logic          mi_ack, mi_err, mi_stall;
  logic          patch_en;
  logic [AW-1:0] pat_addr [NR];
  logic [DW-1:0] pat_data [NR];
  logic [NR-1:0] pat_en;
  logic [15:0]   hit_cnt [NR];

  code_patch_wb_pipe #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .MAX_OUTST(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_si_cyc_i(si_cyc), .wb_si_stb_i(si_stb), .wb_si_we_i(si_we),
    .wb_si_adr_i(si_adr), .wb_si_dat_i(si_dat_i), .wb_si_sel_i(si_sel),
    .wb_si_dat_o(si_dat_o), .wb_si_ack_o(si_ack), .wb_si_err_o(si_err),
    .wb_si_stall_o(si_stall),
    .wb_mi_cyc_o(mi_cyc), .wb_mi_stb_o(mi_stb), .wb_mi_we_o(mi_we),
    .wb_mi_adr_o(mi_adr), .wb_mi_dat_o(mi_dat_o), .wb_mi_sel_o(mi_sel),
    .wb_mi_dat_i(mi_dat_i), .wb_mi_ack_i(mi_ack), .wb_mi_err_i(mi_err),
    .wb_mi_stall_i(mi_stall),
    .cfg_patch_en_i(patch_en),
    .ctl_pat_addr_i(pat_addr), .ctl_pat_data_i(pat_data), .ctl_pat_en_i(pat_en),
    .hit_cnt_o(hit_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Move to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct packed {
    logic          cyc;
    logic          stb;
    logic          we;
    logic          pen;
    logic          mstall;
    logic [AW-1:0] adr;
    logic          exp_mstb;
    logic          exp_stall;
    logic          exp_ack;
    logic [DW-1:0] exp_dat;
  } vec_t;

  vec_t vt [8];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // cyc stb we pen mstall adr          mstb stall ack dat
    vt[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b1, 32'hCAFE0001};
    vt[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 1'b1, 32'h11110002};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h0};
    vt[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'hCAFE0001};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0};

    pat_addr[0] = 32'h100; pat_data[0] = 32'hCAFE0001;
    pat_addr[1] = 32'h104; pat_data[1] = 32'h11110002;
    pat_addr[2] = 32'h100; pat_data[2] = 32'h22220003;
    pat_addr[3] = 32'h300; pat_data[3] = 32'h33330004;
    pat_en   = 4'b0111;
    patch_en = 1'b1;

    rst = 1'b1;
    si_cyc = 1'b1; si_stb = 1'b1; si_we = 1'b0; si_adr = 32'h100;
    si_dat_i = '0; si_sel = '1;
    mi_dat_i = '0; mi_ack = 1'b0; mi_err = 1'b0; mi_stall = 1'b0;

    // ---- reset state (hit request held during reset) ----
    tick(); tick();
    chk("rst ack", {31'd0, si_ack}, 32'd0);
    chk("rst err", {31'd0, si_err}, 32'd0);
    chk("rst dat", si_dat_o, 32'd0);
    chk("rst cnt0", {16'd0, hit_cnt[0]}, 32'd0);
    si_cyc = 1'b0; si_stb = 1'b0;
    rst = 1'b0;
    tick();

    // ---- table-driven single requests ----
    for (int i = 0; i < 8; i++) begin
      si_cyc   = vt[i].cyc;
      si_stb   = vt[i].stb;
      si_we    = vt[i].we;
      patch_en = vt[i].pen;
      mi_stall = vt[i].mstall;
      si_adr   = vt[i].adr;
      si_dat_i = 32'h5A5A0000 + i;
      #1;
      chk($sformatf("v%0d mi_stb", i), {31'd0, mi_stb}, {31'd0, vt[i].exp_mstb});
      chk($sformatf("v%0d stall", i), {31'd0, si_stall}, {31'd0, vt[i].exp_stall});
      chk($sformatf("v%0d mi_adr", i), mi_adr, vt[i].adr);
      tick();
      si_cyc = 1'b1; si_stb = 1'b0; si_we = 1'b0; mi_stall = 1'b0; patch_en = 1'b1;
      #1;
      chk($sformatf("v%0d ack", i), {31'd0, si_ack}, {31'd0, vt[i].exp_ack});
      chk($sformatf("v%0d dat", i), si_dat_o, vt[i].exp_dat);
      tick();
      si_cyc = 1'b0;
      tick();
    end
    chk("tbl cnt0", {16'd0, hit_cnt[0]}, {16'd0, C_CNT_TWO});
    chk("tbl cnt1", {16'd0, hit_cnt[1]}, {16'd0, C_CNT_ONE});
    chk("tbl cnt2", {16'd0, hit_cnt[2]}, 32'd0);

    // ---- async reset clears counters ----
    rst = 1'b1;
    #1;
    chk("mid rst cnt0", {16'd0, hit_cnt[0]}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // ---- duplicate address: entry 0 wins, one-cycle latency ----
    si_cyc = 1'b1; si_stb = 1'b1; si_adr = 32'h100;
    #1;
    chk("dup mi_stb", {31'd0, mi_stb}, 32'd0);
    tick();
    si_stb = 1'b0;
    #1;
    chk("dup ack", {31'd0, si_ack}, 32'd1);
    chk("dup dat", si_dat_o, 32'hCAFE0001);
    tick();
    chk("dup cnt0", {16'd0, hit_cnt[0]}, {16'd0, C_CNT_ONE});
    chk("dup cnt2", {16'd0, hit_cnt[2]}, 32'd0);
    si_cyc = 1'b0;
    tick();

    // ---- forwarded then patched: order preserved ----
    si_cyc = 1'b1; si_stb = 1'b1; si_adr = 32'h200;
    #1;
    chk("ord fwd stb", {31'd0, mi_stb}, 32'd1);
    tick();
    si_adr = 32'h100;
    #1;
    chk("ord hit stb", {31'd0, mi_stb}, 32'd0);
    chk("ord t1 ack", {31'd0, si_ack}, 32'd0);
    tick();
    si_stb = 1'b0;
    #1;
    chk("ord t2 ack", {31'd0, si_ack}, 32'd0);
    tick();
    mi_ack = 1'b1; mi_dat_i = 32'hDEAD0200;
    #1;
    chk("ord slv ack", {31'd0, si_ack}, 32'd1);
    chk("ord slv dat", si_dat_o, 32'hDEAD0200);
    tick();
    mi_ack = 1'b0; mi_dat_i = '0;
    #1;
    chk("ord pat ack", {31'd0, si_ack}, 32'd1);
    chk("ord pat dat", si_dat_o, 32'hCAFE0001);
    tick();
    chk("ord idle ack", {31'd0, si_ack}, 32'd0);
    chk("ord idle dat", si_dat_o, 32'd0);
    si_cyc = 1'b0;
    tick();

    // ---- FIFO full stall with 5 pipelined forwarded reads ----
    si_cyc = 1'b1; si_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      si_adr = 32'h400 + 32'(4 * i);
      #1;
      chk($sformatf("full rd%0d stall", i), {31'd0, si_stall}, 32'd0);
      tick();
    end
    si_adr = 32'h410;
    #1;
    chk("full 5th stall", {31'd0, si_stall}, 32'd1);
    chk("full 5th mi_stb", {31'd0, mi_stb}, 32'd0);
    tick();
    chk("full hold stall", {31'd0, si_stall}, 32'd1);
    mi_ack = 1'b1; mi_dat_i = 32'h4000AAAA;
    #1;
    chk("full ack", {31'd0, si_ack}, 32'd1);
    chk("full ack dat", si_dat_o, 32'h4000AAAA);
    chk("full ack stall", {31'd0, si_stall}, 32'd1);
    tick();
    mi_ack = 1'b0; mi_dat_i = '0;
    #1;
    chk("full free stall", {31'd0, si_stall}, 32'd0);
    chk("full free mi_stb", {31'd0, mi_stb}, 32'd1);
    tick();
    si_stb = 1'b0; si_cyc = 1'b0;
    tick();

    // ---- abort with two patched reads pending behind a forwarded one ----
    si_cyc = 1'b1; si_stb = 1'b1; si_adr = 32'h200;
    tick();
    si_adr = 32'h100;
    tick();
    si_adr = 32'h104;
    #1;
    chk("abt t2 ack", {31'd0, si_ack}, 32'd0);
    tick();
    si_stb = 1'b0; si_cyc = 1'b0;
    #1;
    chk("abt drop ack", {31'd0, si_ack}, 32'd0);
    tick();
    si_cyc = 1'b1;
    #1;
    chk("abt after ack", {31'd0, si_ack}, 32'd0);
    tick();
    mi_ack = 1'b1; mi_dat_i = 32'hBAD00001;
    #1;
    chk("stray ack", {31'd0, si_ack}, 32'd0);
    chk("stray dat", si_dat_o, 32'd0);
    tick();
    mi_ack = 1'b0; mi_dat_i = '0;
    #1;
    chk("stray after", {31'd0, si_ack}, 32'd0);
    tick();

    // ---- pending patched ack cancelled in the cycle cyc falls ----
    si_stb = 1'b1; si_adr = 32'h104;
    tick();
    si_stb = 1'b0; si_cyc = 1'b0;
    #1;
    chk("cancel ack", {31'd0, si_ack}, 32'd0);
    chk("cancel dat", si_dat_o, 32'd0);
    tick();
    si_cyc = 1'b1;
    #1;
    chk("cancel after", {31'd0, si_ack}, 32'd0);
    tick();

    // ---- bus error passes through for a forwarded head ----
    si_stb = 1'b1; si_adr = 32'h500;
    tick();
    si_stb = 1'b0; mi_err = 1'b1; mi_dat_i = 32'h12345678;
    #1;
    chk("err err", {31'd0, si_err}, 32'd1);
    chk("err ack", {31'd0, si_ack}, 32'd0);
    chk("err dat", si_dat_o, 32'd0);
    tick();
    mi_err = 1'b0; mi_dat_i = '0;
    #1;
    chk("err after", {31'd0, si_err}, 32'd0);
    si_cyc = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/code_patch_wb_pipe.md
CODE_PATCH_WB_PIPE -- requirements
Module: code_patch_wb_pipe

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width, a multiple of 8; SEL_WIDTH = DATA_WIDTH/8.
REQ-003 SHALL have parameter NUM_REGS, default 4, number of patch entries, 1..16.
REQ-004 SHALL have parameter MAX_OUTST, default 4, outstanding-transaction depth, a power of 2, at least 2.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk_i  in  1  rising-edge clock.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 wb_si_cyc_i / wb_si_stb_i / wb_si_we_i  in  1 each  CPU-side pipelined Wishbone cycle, strobe, write.
REQ-008 wb_si_adr_i  in  ADDR_WIDTH  CPU address.
REQ-009 wb_si_dat_i  in  DATA_WIDTH; wb_si_sel_i  in  SEL_WIDTH  write data and byte select.
REQ-010 wb_si_dat_o  out  DATA_WIDTH  read data.
REQ-011 wb_si_ack_o / wb_si_err_o / wb_si_stall_o  out  1 each  ack, error, stall.
REQ-012 wb_mi_cyc_o / wb_mi_stb_o / wb_mi_we_o  out  1 each  bus-side cycle, strobe, write.
REQ-013 wb_mi_adr_o  out  ADDR_WIDTH; wb_mi_dat_o  out  DATA_WIDTH; wb_mi_sel_o  out  SEL_WIDTH  forwarded request.
REQ-014 wb_mi_dat_i  in  DATA_WIDTH; wb_mi_ack_i / wb_mi_err_i / wb_mi_stall_i  in  1 each  bus response.
REQ-015 cfg_patch_en_i  in  1  global patch enable.
REQ-016 ctl_pat_addr_i  in  ADDR_WIDTH x NUM_REGS (unpacked)  patch addresses.
REQ-017 ctl_pat_data_i  in  DATA_WIDTH x NUM_REGS (unpacked)  patch data.
REQ-018 ctl_pat_en_i  in  NUM_REGS  per-entry enable.
REQ-019 hit_cnt_o  out  16 x NUM_REGS (unpacked)  per-entry hit counters.

Function
REQ-020 Hit SHALL be: cyc & stb & !we & cfg_patch_en_i & ctl_pat_en_i[k] & adr==ctl_pat_addr_i[k]; lowest k wins; writes are never patched.
REQ-021 Accept SHALL be: cyc & stb & !wb_si_stall_o; wb_si_stall_o = fifo_full | (!hit & wb_mi_stall_i).
REQ-022 Non-hit requests SHALL pass combinationally: wb_mi_stb_o = stb & !hit & !fifo_full; adr/dat/sel/we direct; wb_mi_cyc_o = wb_si_cyc_i.
REQ-023 Each accept SHALL push one entry {patched, k, data} into an in-order FIFO of MAX_OUTST entries; push and pop in the same cycle are allowed.
REQ-024 Head forwarded: wb_mi_ack_i/err_i SHALL pop it and pass to wb_si_ack_o/err_o with wb_si_dat_o = wb_mi_dat_i in the same cycle.
REQ-025 Head patched: the block SHALL assert wb_si_ack_o for one cycle, wb_si_dat_o = data captured at accept, on the cycle after the entry reaches the head (one-cycle latency when the FIFO was empty), then pop.
REQ-026 Responses SHALL return in request order; a patched ack never overtakes an earlier forwarded request.
REQ-027 wb_mi_ack_i/err_i with an empty FIFO or a patched head SHALL be dropped, not forwarded.
REQ-028 wb_si_cyc_i falling SHALL flush the FIFO and cancel any pending patched ack in that cycle.
REQ-029 wb_si_dat_o SHALL be 0 in any cycle without ack.

Reset
REQ-030 rst_i SHALL asynchronously empty the FIFO, clear the patched-ack register and counters; wb_si_ack_o, wb_si_err_o and hit_cnt_o read 0 while rst_i is high.

Configuration
REQ-031 With CODE_PATCH_HIT_CNT_EN defined, each hit_cnt_o[k] SHALL increment once per accepted hit on entry k, saturating at 0xFFFF; without it hit_cnt_o SHALL be constant 0 and no counter flops exist.

Verification
REQ-032 Entry0 addr 0x100 data 0xCAFE0001 enabled, read 0x100, FIFO empty -> ack next cycle, dat 0xCAFE0001, wb_mi_stb_o stays 0.
REQ-033 Forwarded read 0x200 (slave acks 3 cycles later) then hit 0x100 back-to-back -> slave data acked first, patch ack one cycle after.
REQ-034 Entries 0 and 2 both 0x100 with differing data -> entry-0 data returned; hit_cnt_o[0]=1, [2]=0 with macro.
REQ-035 MAX_OUTST=4, slave stalls acks, 5 pipelined forwarded reads -> wb_si_stall_o high on the 5th until first ack.
REQ-036 Two patched reads pending, wb_si_cyc_i dropped -> no ack afterwards; unsolicited wb_mi_ack_i -> wb_si_ack_o stays 0.
